// File: rtl/jmb_win3_feed_pkg.sv
// Shared definitions for the 3-tap window feeder: FSM state encodings and
// the shift amounts handed to the divider-adder.
package jmb_win3_feed_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int SHIFT_121 = 2;
    localparam int SHIFT_BYP = 0;

endpackage

// File: rtl/jmb_win3_oreg.sv
// Single-entry valid/ready output register for the window tuple; contents are
// held stable while the downstream stalls.
module jmb_win3_oreg #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] add_1_next,
    input  logic [DATA_W-1:0] add_2_next,
    input  logic [DATA_W-1:0] add_3_next,
    input  logic [DATA_W-1:0] shift_next,
    input  logic              first_next,
    input  logic              last_next,
    input  logic              ready,
    output logic              slot_free,
    output logic              valid,
    output logic [DATA_W-1:0] add_1,
    output logic [DATA_W-1:0] add_2,
    output logic [DATA_W-1:0] add_3,
    output logic [DATA_W-1:0] shift,
    output logic              first,
    output logic              last
);

    assign slot_free = !valid || ready;

    // load is only raised by the producer when slot_free is true
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            add_1 <= '0;
            add_2 <= '0;
            add_3 <= '0;
            shift <= '0;
            first <= 1'b0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            add_1 <= add_1_next;
            add_2 <= add_2_next;
            add_3 <= add_3_next;
            shift <= shift_next;
            first <= first_next;
            last  <= last_next;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/jmb_win3_feed.sv
// Streaming 3-tap window generator: turns a sample stream into (left, centre,
// right) tuples with edge replication, encoded for 1-2-1 smoothing or bypass.
module jmb_win3_feed
    import jmb_win3_feed_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LEN_W-1:0]  line_len,
    input  logic              mode_121,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] add_1,
    output logic [DATA_W-1:0] add_2,
    output logic [DATA_W-1:0] add_3,
    output logic [DATA_W-1:0] shift,
    output logic              out_first,
    output logic              out_last
);

    state_t            state_reg;
    logic [DATA_W-1:0] prev_reg;
    logic [DATA_W-1:0] cur_reg;
    logic [LEN_W-1:0]  cnt_reg;
    logic [LEN_W-1:0]  len_reg;
    logic              mode_reg;
    logic              first_reg;

    logic              slot_free;
    logic              accept;
    logic              emit;
    logic [LEN_W-1:0]  len_eff;
    logic [LEN_W-1:0]  cnt_next;
    logic [DATA_W-1:0] right;
    logic [DATA_W-1:0] add_1_next;
    logic [DATA_W-1:0] add_2_next;
    logic [DATA_W-1:0] add_3_next;
    logic [DATA_W-1:0] shift_next;

    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            case (state_reg)
                ST_IDLE: in_ready = 1'b1;
                ST_RUN:  in_ready = slot_free;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept   = in_valid && in_ready;
    assign emit     = (state_reg == ST_RUN && accept) || (state_reg == ST_FLUSH && slot_free);
    assign len_eff  = (line_len == '0) ? LEN_W'(1) : line_len;
    assign cnt_next = cnt_reg + LEN_W'(1);
    // the final tuple replicates the last sample as its right neighbour
    assign right    = (state_reg == ST_FLUSH) ? cur_reg : in_data;

    always_comb begin
        if (mode_reg) begin
            add_1_next = prev_reg;
            add_2_next = {cur_reg[DATA_W-2:0], 1'b0};
            add_3_next = right;
            shift_next = DATA_W'(SHIFT_121);
        end else begin
            add_1_next = '0;
            add_2_next = cur_reg;
            add_3_next = '0;
            shift_next = DATA_W'(SHIFT_BYP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            prev_reg  <= '0;
            cur_reg   <= '0;
            cnt_reg   <= '0;
            len_reg   <= '0;
            mode_reg  <= 1'b0;
            first_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        prev_reg  <= in_data;
                        cur_reg   <= in_data;
                        cnt_reg   <= LEN_W'(1);
                        len_reg   <= len_eff;
                        mode_reg  <= mode_121;
                        first_reg <= 1'b1;
                        state_reg <= (len_eff == LEN_W'(1)) ? ST_FLUSH : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        prev_reg  <= cur_reg;
                        cur_reg   <= in_data;
                        cnt_reg   <= cnt_next;
                        first_reg <= 1'b0;
                        if (cnt_next == len_reg) begin
                            state_reg <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (slot_free) begin
                        first_reg <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    jmb_win3_oreg #(
        .DATA_W(DATA_W)
    ) u_oreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (emit),
        .add_1_next (add_1_next),
        .add_2_next (add_2_next),
        .add_3_next (add_3_next),
        .shift_next (shift_next),
        .first_next (first_reg),
        .last_next  (state_reg == ST_FLUSH),
        .ready      (out_ready),
        .slot_free  (slot_free),
        .valid      (out_valid),
        .add_1      (add_1),
        .add_2      (add_2),
        .add_3      (add_3),
        .shift      (shift),
        .first      (out_first),
        .last       (out_last)
    );

endmodule
